// File: rtl/bsg_adder_sum_accumulator_if.sv
// bsg_adder_sum_accumulator_if: adder-result input and accumulated-total output handshakes
interface bsg_adder_sum_accumulator_if #(
  parameter int width_p = 128,
  parameter int els_p = 4
);
  localparam int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p);
  localparam int acc_width_lp = width_p + 1 + lg_els_lp;
  logic v_i;
  logic [width_p-1:0] s_i;
  logic c_i;
  logic ready_o;
  logic v_o;
  logic [acc_width_lp-1:0] sum_o;
  logic ready_i;
  logic [lg_els_lp:0] count_o;
  modport master (output v_i, s_i, c_i, ready_i, input ready_o, v_o, sum_o, count_o);
  modport slave (input v_i, s_i, c_i, ready_i, output ready_o, v_o, sum_o, count_o);
endinterface

// File: rtl/bsg_adder_sum_accumulator.sv
// bsg_adder_sum_accumulator: sums els_p consecutive {carry,sum} adder results into one widened total
module bsg_adder_sum_accumulator #(
  parameter int width_p = 128,
  parameter int els_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_adder_sum_accumulator_if.slave io
);
  localparam int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p);
  localparam int acc_width_lp = width_p + 1 + lg_els_lp;
  localparam logic [lg_els_lp:0] els_lp = (lg_els_lp+1)'(els_p);
  typedef enum logic {ACCUM, FULL} state_e;
  state_e r_state;
  logic [acc_width_lp-1:0] r_acc;
  logic [lg_els_lp:0] r_count;
  logic w_accept, w_out;
  logic [lg_els_lp:0] w_count_nxt;
  logic [acc_width_lp-1:0] w_in;
  logic [acc_width_lp:0] w_sum;
  // gate the operand so undriven s_i/c_i never reach the adder when v_i is low
  assign w_in = io.v_i ? acc_width_lp'({io.c_i, io.s_i}) : '0;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_in};
  assign w_count_nxt = r_count + 1'b1;
  assign io.ready_o = ~reset_i & ((r_state == ACCUM) | io.ready_i);
  assign io.v_o = (r_state == FULL);
  assign io.sum_o = r_acc;
  assign io.count_o = r_count;
  assign w_accept = io.v_i & io.ready_o;
  assign w_out = io.v_o & io.ready_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ACCUM;
      r_acc <= '0;
      r_count <= '0;
    end else if (r_state == ACCUM) begin
      if (w_accept) begin
        r_acc <= w_sum[acc_width_lp-1:0];
        r_count <= w_count_nxt;
        r_state <= (w_count_nxt == els_lp) ? FULL : ACCUM;
      end
    end else if (w_out) begin
      r_acc <= w_accept ? w_in : '0;
      r_count <= w_accept ? (lg_els_lp+1)'(1) : '0;
      r_state <= (w_accept && els_p == 1) ? FULL : ACCUM;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i && r_state == ACCUM && w_accept)
      assert (!w_sum[acc_width_lp]) else $error("accumulator wrapped");
  end
endmodule

// File: tb/tb_bsg_adder_sum_accumulator.sv
// tb_bsg_adder_sum_accumulator: directed vectors against els_p=4 and els_p=1 builds
module tb_bsg_adder_sum_accumulator;
  logic clk = 0;
  logic rst = 1;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bsg_adder_sum_accumulator_if #(.width_p(128), .els_p(4)) a_if ();
  bsg_adder_sum_accumulator_if #(.width_p(128), .els_p(1)) b_if ();
  bsg_adder_sum_accumulator #(.width_p(128), .els_p(4)) dut_a (.clk_i(clk), .reset_i(rst), .io(a_if.slave));
  bsg_adder_sum_accumulator #(.width_p(128), .els_p(1)) dut_b (.clk_i(clk), .reset_i(rst), .io(b_if.slave));
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic put_a(input logic v, input logic c, input logic [127:0] s);
    a_if.v_i = v;
    a_if.c_i = c;
    a_if.s_i = s;
  endtask
  initial begin
    logic [255:0] big;
    int grp;
    put_a(0, 0, 0);
    a_if.ready_i = 1;
    b_if.v_i = 0;
    b_if.c_i = 0;
    b_if.s_i = 0;
    b_if.ready_i = 1;
    cyc();
    cyc();
    chk("ready_in_reset", a_if.ready_o, 0);
    chk("reset_v_o", a_if.v_o, 0);
    chk("reset_count", a_if.count_o, 0);
    chk("reset_sum", a_if.sum_o, 0);
    rst = 0;
    #1;
    chk("ready_after_reset", a_if.ready_o, 1);
    // four spaced accepts of 1, with garbage on the data lines while idle
    for (int i = 0; i < 4; i++) begin
      put_a(1, 0, 1);
      cyc();
      put_a(0, 1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
      chk($sformatf("t1_count%0d", i), a_if.count_o, i + 1);
      chk($sformatf("t1_v_o%0d", i), a_if.v_o, i == 3);
      if (i == 3) chk("t1_sum", a_if.sum_o, 4);
      else chk($sformatf("t1_partial%0d", i), a_if.sum_o, i + 1);
      cyc();
    end
    chk("t1_drain_v_o", a_if.v_o, 0);
    chk("t1_drain_count", a_if.count_o, 0);
    // full-width carry path
    for (int i = 0; i < 4; i++) begin
      put_a(1, 1, '1);
      cyc();
    end
    put_a(0, 0, 0);
    big = (256'd1 << 131) - 256'd4;
    chk("t2_v_o", a_if.v_o, 1);
    chk("t2_sum", a_if.sum_o, big);
    cyc();
    chk("t2_drain", a_if.v_o, 0);
    // backpressure with v_i held high
    a_if.ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      put_a(1, 0, 1);
      cyc();
    end
    put_a(1, 0, 7);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_ready%0d", i), a_if.ready_o, 0);
      chk($sformatf("t3_v_o%0d", i), a_if.v_o, 1);
      chk($sformatf("t3_sum%0d", i), a_if.sum_o, 4);
      chk($sformatf("t3_count%0d", i), a_if.count_o, 4);
      cyc();
    end
    a_if.ready_i = 1;
    #1;
    chk("t3_ready_release", a_if.ready_o, 1);
    cyc();
    chk("t3_next_v_o", a_if.v_o, 0);
    chk("t3_next_sum", a_if.sum_o, 7);
    chk("t3_next_count", a_if.count_o, 1);
    // second partial accept, then reset discards the group
    put_a(1, 0, 5);
    cyc();
    put_a(0, 0, 0);
    chk("t5_partial_count", a_if.count_o, 2);
    rst = 1;
    #1;
    chk("t5_ready_in_reset", a_if.ready_o, 0);
    cyc();
    rst = 0;
    chk("t5_reset_v_o", a_if.v_o, 0);
    chk("t5_reset_count", a_if.count_o, 0);
    chk("t5_reset_sum", a_if.sum_o, 0);
    for (int i = 0; i < 4; i++) begin
      put_a(1, 0, 5);
      cyc();
      chk($sformatf("t5_v_o%0d", i), a_if.v_o, i == 3);
    end
    put_a(0, 0, 0);
    chk("t5_sum", a_if.sum_o, 20);
    cyc();
    chk("t5_drain", a_if.v_o, 0);
    // continuous stream 1..12
    for (int k = 1; k <= 12; k++) begin
      put_a(1, 0, 128'(k));
      chk($sformatf("t4_ready%0d", k), a_if.ready_o, 1);
      cyc();
      chk($sformatf("t4_v_o%0d", k), a_if.v_o, (k % 4) == 0);
      if (k % 4 == 0) begin
        grp = 4 * k - 6;
        chk($sformatf("t4_sum%0d", k), a_if.sum_o, grp);
      end
    end
    put_a(0, 0, 0);
    cyc();
    chk("t4_end_v_o", a_if.v_o, 0);
    chk("t4_end_count", a_if.count_o, 0);
    // els_p == 1 build
    b_if.v_i = 1;
    b_if.s_i = 9;
    cyc();
    b_if.s_i = 3;
    chk("t6_v_o9", b_if.v_o, 1);
    chk("t6_sum9", b_if.sum_o, 9);
    chk("t6_count9", b_if.count_o, 1);
    chk("t6_ready", b_if.ready_o, 1);
    cyc();
    b_if.v_i = 0;
    chk("t6_v_o3", b_if.v_o, 1);
    chk("t6_sum3", b_if.sum_o, 3);
    cyc();
    chk("t6_end_v_o", b_if.v_o, 0);
    chk("t6_end_count", b_if.count_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bsg_adder_sum_accumulator.md
Name: bsg_adder_sum_accumulator

Overview:
- Downstream consumer of the wide ripple-carry adder. Takes each {carry, sum} result over a valid/ready handshake and accumulates els_p consecutive results into a widened register.
- Presents the total over a valid/ready output handshake.
- Used to reduce streams of 128-bit partial sums, such as checksums or multi-word reductions, without a second wide adder stage in the datapath.

Parameters:
- width_p, 128, width of incoming sum s_i; the incoming value is width_p+1 bits including c_i.
- els_p, 4, number of adder results accumulated per output; legal range is 1 or more.
- lg_els_lp, `BSG_SAFE_CLOG2(els_p), derived; not user-set.
- acc_width_lp, width_p+1+lg_els_lp, derived; accumulator and output width.

Ports:
- clk_i, input, 1, clock.
- reset_i, input, 1, synchronous active-high reset.
- v_i, input, 1, adder result valid.
- s_i, input, width_p, adder sum bits.
- c_i, input, 1, adder carry-out; forms bit width_p of the incoming value.
- ready_o, input-side ready, output, 1, accumulator accepts a result this cycle.
- v_o, output, 1, accumulated total valid.
- sum_o, output, acc_width_lp, accumulated total.
- ready_i, input, 1, downstream accepts sum_o this cycle.
- count_o, output, lg_els_lp+1, number of results absorbed into the current accumulation.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset: on the edge where reset_i is high, set state to ACCUM, acc to 0, count_o to 0, v_o to 0. ready_o is 0 while reset_i is high.
- Incoming operand: in_val = {c_i, s_i}, zero-extended to acc_width_lp. It never overflows, because els_p*(2^(width_p+1)-1) is less than 2^acc_width_lp.
- Accept event: v_i & ready_o. Output event: v_o & ready_i.
- ready_o = ~reset_i & (state==ACCUM | ready_i); the output register drains and refills in the same cycle.
- States:
  - ACCUM: output idle; collecting results.
  - FULL: v_o=1; sum_o holds the total.
- In ACCUM, on accept:
  - acc <= acc + in_val, and count <= count+1.
  - If count+1 == els_p, go to FULL the next cycle. sum_o = final acc, and count_o stays at els_p.
- In ACCUM with no accept: hold all state.
- In FULL with no output event: hold sum_o, v_o and count_o stable. They must not change while v_o=1 and ready_i=0.
- In FULL, output event without accept: acc <= 0, count <= 0, go to ACCUM.
- In FULL, output event with simultaneous accept: acc <= in_val and count <= 1. The accepted result is the first of the next group, with no bubble.
  - If els_p==1, stay in FULL with sum_o = in_val.
- Latency: v_o rises the cycle after the els_p-th accept. Sustained throughput is one result per cycle with ready_i held high.
- sum_o equals acc in all states; it is meaningful only when v_o=1.
- v_i with ready_o=0: no state change; the upstream holds its data (standard valid/ready).
- Reset mid-accumulation or while FULL: all partial state is discarded. No v_o pulse for the partial group.
- s_i and c_i are don't-care when v_i=0; X on them must not propagate into acc.
- Arithmetic is unsigned. No internal wrap can occur; assert this in simulation.

Test Plan:
- Reset, then 4 accepts of {c=0, s=1}, each followed by one idle cycle, with ready_i=1 → v_o=1 one cycle after the 4th accept. sum_o=4 and count_o=4. Then v_o=0 and count_o=0.
- 4 back-to-back accepts of {c=1, s=all-ones} → sum_o = 4*(2^129-1) = 0x7_FFFF…FFFC (131 bits); verifies the full-width carry path.
- Group complete with ready_i=0 for 5 cycles, v_i held high → ready_o=0 and sum_o stable for 5 cycles. When ready_i=1, the output event and an accept of value 7 coincide: the next group starts with acc=7 and count_o=1.
- Continuous stream of values 1,2,3,… with ready_i=1 → outputs 10, 26, 42 on every 4th+1 cycle, with no dropped or duplicated inputs.
- reset_i asserted after 2 of 4 accepts → no v_o. The next 4 accepts of 5 give sum_o=20.
- els_p=1 build, stream of values 9,3 with ready_i=1 → v_o stays high and sum_o=9 then 3, one per cycle.
